mux_pipe: RTL and testbench
===========================

Name: mux_pipe

Overview:
- Pipelined, parametrised S-to-1 selector for the NTT datapath; out = a[sel].
- Successor to the combinational mux tree.
- Adds:
  - arbitrary (non-power-of-2) input count
  - configurable pipeline register insertion every STAGE tree levels
  - valid/ready flow control with per-stage bubble collapsing
  - out-of-range select detection
- Used between the coefficient bank read ports and the butterfly units, where the wide combinational tree limits timing.

Parameters:
- N, 64, data width per input.
- S, 64, number of inputs; S >= 2, need not be a power of 2.
- STAGE, 2, tree levels per pipeline stage; 1 <= STAGE <= L.
- Derived:
  - L = $clog2(S), number of tree levels.
  - P = ceil(L/STAGE), number of register stages (latency).

Ports:
- clk       input   1            clock, rising edge
- rst       input   1            synchronous reset, active-high
- in_valid  input   1            a/sel valid
- in_ready  output  1            block accepts a/sel this cycle
- a         input   S*N          packed inputs; input k = a[N*k +: N]
- sel       input   L            binary select index
- out_valid output  1            s/err valid
- out_ready input   1            downstream accepts s/err
- s         output  N            selected data
- err       output  1            sel >= S for this result

Behaviour:
- Reset:
  - rst is sampled on the rising clk edge and has priority over all other activity.
  - All stage valid bits clear to 0. out_valid=0, s=0, err=0.
  - Stage data registers clear to 0.
  - After reset, in_ready=1.
- Tree structure:
  - Level 0 (leaf) pairs inputs (2j, 2j+1) under sel[0]; level m uses sel[m].
  - Result is the standard binary index a[sel].
  - Inputs with index >= S are padding, tied to 0.
- Pipeline:
  - A register stage sits after levels STAGE-1, 2*STAGE-1, ..., and always after level L-1.
  - Each stage carries: surviving partial mux words, remaining sel bits (sel[L-1:m]), err bit, valid bit.
  - err is computed combinationally at input (sel >= S) and travels with the data.
- Latency: an accepted beat appears at out_valid exactly P cycles later when no stall occurs.
- Throughput: one beat per cycle when out_ready=1 continuously.
- Handshake:
  - Stage k loads when its valid is 0 or stage k+1 loads; the last stage loads when out_valid=0 or out_ready=1.
  - in_ready = stage-0 load enable.
  - Transfer occurs when in_valid&&in_ready (input side) or out_valid&&out_ready (output side).
  - A stage that loads with no upstream valid data becomes invalid (bubble); bubbles are squeezed out under backpressure.
  - While out_valid=1 and out_ready=0, s and err hold stable.
  - a and sel are don't-care when in_valid=0; invalid stages never raise out_valid.
- Out-of-range select:
  - When sel >= S: s=0, err=1, out_valid asserts normally (no drop).
- Simultaneous events:
  - Output pop and input push in the same cycle with the pipeline full: both occur, and occupancy is unchanged.
  - rst in the same cycle as a transfer: reset wins, and the beat is lost.
- Reset mid-operation: all in-flight beats are discarded; out_valid=0 the next cycle.
- Capacity: at most P beats in flight; in_ready=0 only when all P stages are valid and out_ready=0.
- Contract: S=2^L, STAGE=L, out_ready tied high, in_valid tied high gives a 1-cycle registered version of the old combinational tree.

Test Plan:
1. Streaming, no stall:
   - Config: N=8, S=5, STAGE=1 (L=3, P=3); a = {0x55,0x44,0x33,0x22,0x11} (input 0 = 0x11); out_ready=1.
   - Drive sel=0,1,2,3,4 on consecutive cycles with in_valid=1.
   - Required: out_valid high from cycle 3; s = 0x11,0x22,0x33,0x44,0x55 back-to-back; err=0.
2. Out-of-range select:
   - Same config; sel=5, then 7.
   - Required: s=0x00 with err=1 for both, 3 cycles after each accept.
3. Backpressure:
   - Same config; stream 6 beats with out_ready=0 from cycle 2.
   - Required: in_ready falls after 3 beats accepted; s holds the first result stably.
   - Release out_ready: results drain in order with no loss or duplication.
4. Bubble collapse:
   - Same config; in_valid pulses every other cycle while out_ready=0 for 4 cycles.
   - Required: 3 beats accepted before in_ready=0; on release, 3 consecutive out_valid cycles.
5. Reset mid-stream:
   - Same config; assert rst for 1 cycle with 2 beats in flight.
   - Required: next cycle out_valid=0, s=0, in_ready=1; no stale beat emerges afterwards.
6. Max config, random:
   - Config: N=64, S=64, STAGE=2 (P=3); random sel, random in_valid/out_ready for 10k cycles.
   - Required: scoreboard matches a[sel] in order; err never set.

Source files
------------

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - pipelined S-to-1 selector with valid/ready flow control
// A register stage follows every STAGE tree levels; each stage folds its levels into one direct index.
module mux_pipe #(
    parameter int N     = 64,
    parameter int S     = 64,
    parameter int STAGE = 2,
    localparam int L    = $clog2(S),
    localparam int P    = (L + STAGE - 1) / STAGE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [S*N-1:0] a,
    input  logic [L-1:0]   sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   s,
    output logic           err
);

    localparam int SP = 1 << L;
    localparam logic [L:0] S_W = (L + 1)'(S);

    logic [SP*N-1:0] a_pad;
    logic            err_in;
    logic [P-1:0]    vld;
    logic [P-1:0]    ld;

    // Padding words are zero, so an out-of-range select naturally yields s=0.
    always_comb begin
        a_pad = '0;
        a_pad[S*N-1:0] = a;
    end

    assign err_in = ({1'b0, sel} >= S_W);

    // Stage k loads when empty or when its successor loads; this squeezes out bubbles.
    always_comb begin
        ld = '0;
        ld[P-1] = !vld[P-1] || out_ready;
        for (int k = P - 2; k >= 0; k--) begin
            ld[k] = !vld[k] || ld[k+1];
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_stg
        localparam int MB = p * STAGE;
        localparam int ME = (MB + STAGE < L) ? MB + STAGE : L;
        localparam int SB = ME - MB;
        localparam int WI = 1 << (L - MB);
        localparam int WO = 1 << (L - ME);
        localparam int G  = 1 << SB;

        logic [WI*N-1:0] din;
        logic [L-MB-1:0] sin;
        logic            vin;
        logic            ein;
        logic [SB-1:0]   sub;
        logic [WO*N-1:0] data_d;
        logic [WO*N-1:0] data_q;
        logic            vld_q;
        logic            err_q;

        if (p == 0) begin : g_src
            assign din = a_pad;
            assign sin = sel;
            assign vin = in_valid;
            assign ein = err_in;
        end else begin : g_src
            assign din = g_stg[p-1].data_q;
            assign sin = g_stg[p-1].g_rest.sel_q;
            assign vin = g_stg[p-1].vld_q;
            assign ein = g_stg[p-1].err_q;
        end

        assign sub = sin[SB-1:0];

        // SB binary levels collapse to picking word sub within each group of G.
        always_comb begin
            data_d = '0;
            for (int j = 0; j < WO; j++) begin
                data_d[j*N +: N] = din[(j * G + int'(sub)) * N +: N];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                err_q  <= 1'b0;
                data_q <= '0;
            end else if (ld[p]) begin
                vld_q <= vin;
                if (vin) begin
                    data_q <= data_d;
                    err_q  <= ein;
                end
            end
        end

        if (p < P - 1) begin : g_rest
            logic [L-ME-1:0] sel_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_q <= '0;
                end else if (ld[p] && vin) begin
                    sel_q <= sin[L-MB-1:SB];
                end
            end
        end

        assign vld[p] = vld_q;
    end

    assign in_ready  = ld[0];
    assign out_valid = g_stg[P-1].vld_q;
    assign s         = g_stg[P-1].data_q;
    assign err       = g_stg[P-1].err_q;

endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - directed and random checks of mux_pipe
module tb_mux_pipe;

    logic clk = 1'b0;
    logic rst;

    logic        iv1, ir1, ov1, or1, err1;
    logic [39:0] a1;
    logic [2:0]  sel1;
    logic [7:0]  s1;

    logic          iv2, ir2, ov2, or2, err2;
    logic [4095:0] a2;
    logic [5:0]    sel2;
    logic [63:0]   s2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_pipe #(.N(8), .S(5), .STAGE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .sel(sel1),
        .out_valid(ov1), .out_ready(or1), .s(s1), .err(err1)
    );

    mux_pipe #(.N(64), .S(64), .STAGE(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .sel(sel2),
        .out_valid(ov2), .out_ready(or2), .s(s2), .err(err2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // input k of u1 holds 0x11*(k+1)
    function automatic logic [63:0] dat(input int k);
        return 64'(17 * (k + 1));
    endfunction

    initial begin
        int np;
        int npop;
        int sels3[6];
        logic [63:0] q[$];

        sels3 = '{2, 0, 4, 1, 3, 2};
        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b1; sel1 = '0;
        a1  = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        iv2 = 1'b0; or2 = 1'b1; sel2 = '0; a2 = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(ov1), 64'd0);
        check("rst_s", 64'(s1), 64'd0);
        check("rst_err", 64'(err1), 64'd0);
        check("rst_in_ready", 64'(ir1), 64'd1);
        check("rst_in_ready_max", 64'(ir2), 64'd1);

        // streaming, no stall
        for (int c = 0; c < 9; c++) begin
            iv1  = (c < 5);
            sel1 = 3'(c % 5);
            #1;
            check("t1_out_valid", 64'(ov1), 64'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) begin
                check("t1_s", 64'(s1), dat(c - 3));
                check("t1_err", 64'(err1), 64'd0);
            end
            tick();
        end

        // out-of-range select
        for (int c = 0; c < 6; c++) begin
            iv1  = (c < 2);
            sel1 = (c == 0) ? 3'd5 : 3'd7;
            #1;
            check("t2_out_valid", 64'(ov1), 64'(c == 3 || c == 4));
            if (c == 3 || c == 4) begin
                check("t2_s", 64'(s1), 64'd0);
                check("t2_err", 64'(err1), 64'd1);
            end
            tick();
        end

        // backpressure from cycle 2, released at cycle 6
        np = 0; npop = 0;
        for (int c = 0; c < 16; c++) begin
            iv1  = (np < 6);
            sel1 = 3'(sels3[(np < 6) ? np : 0]);
            or1  = (c < 2 || c >= 6);
            #1;
            if (c == 3) check("t3_accepted", 64'(np), 64'd3);
            if (c >= 3 && c < 6) begin
                check("t3_in_ready_low", 64'(ir1), 64'd0);
                check("t3_hold_valid", 64'(ov1), 64'd1);
                check("t3_hold_s", 64'(s1), dat(sels3[0]));
            end
            if (ov1 && or1) begin
                if (npop < 6) check("t3_order", 64'(s1), dat(sels3[npop]));
                else check("t3_extra", 64'(npop), 64'd5);
                npop++;
            end
            if (iv1 && ir1) np++;
            tick();
        end
        check("t3_pops", 64'(npop), 64'd6);
        check("t3_drained", 64'(ov1), 64'd0);

        // bubble collapse: inputs every other cycle under backpressure
        np = 0; npop = 0;
        for (int c = 0; c < 11; c++) begin
            iv1  = (c % 2 == 0) && (np < 3);
            sel1 = 3'(np % 5);
            or1  = (c >= 7);
            #1;
            if (c == 5 || c == 6) check("t4_in_ready_low", 64'(ir1), 64'd0);
            if (c == 6) check("t4_hold_s", 64'(s1), dat(0));
            if (c == 10) check("t4_drained", 64'(ov1), 64'd0);
            if (ov1 && or1) begin
                check("t4_pop_cycle", 64'(c), 64'(7 + npop));
                check("t4_s", 64'(s1), dat(npop));
                npop++;
            end
            if (iv1 && ir1) np++;
            tick();
        end
        check("t4_accepted", 64'(np), 64'd3);
        check("t4_pops", 64'(npop), 64'd3);

        // reset with two beats in flight
        or1 = 1'b1;
        iv1 = 1'b1; sel1 = 3'd1; tick();
        sel1 = 3'd2; tick();
        rst = 1'b1; sel1 = 3'd3; tick();
        rst = 1'b0; iv1 = 1'b0;
        #1;
        check("t5_out_valid", 64'(ov1), 64'd0);
        check("t5_s", 64'(s1), 64'd0);
        check("t5_in_ready", 64'(ir1), 64'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t5_no_stale", 64'(ov1), 64'd0);
        end

        // max config, random traffic against a scoreboard
        npop = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 64; k++) a2[k*64 +: 64] = {$urandom, $urandom};
            sel2 = 6'($urandom_range(63));
            iv2  = ($urandom_range(3) != 0);
            or2  = ($urandom_range(3) != 0);
            #1;
            if (ov2 && or2) begin
                if (q.size() == 0) check("t6_underflow", 64'(q.size()), 64'd1);
                else check("t6_s", s2, q.pop_front());
                check("t6_err", 64'(err2), 64'd0);
                npop++;
            end
            if (iv2 && ir2) q.push_back(a2[int'(sel2)*64 +: 64]);
            tick();
        end
        iv2 = 1'b0; or2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ov2) begin
                if (q.size() == 0) check("t6_underflow", 64'(q.size()), 64'd1);
                else check("t6_s", s2, q.pop_front());
            end
            tick();
        end
        check("t6_queue_empty", 64'(q.size()), 64'd0);
        check("t6_traffic", 64'(npop > 1000), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
